// File: rtl/gpio_controller_pkg.sv
// Shared GPIO controller constants: pin count, interrupt grouping and default
// widths for the input filter's prescaler and stability counters.
package gpio_controller_pkg;

  localparam int unsigned GPIO_NUM       = 256;
  localparam int unsigned GPIO_GROUPS    = 8;
  localparam int unsigned GPIO_GROUP_W   = GPIO_NUM / GPIO_GROUPS;
  localparam int unsigned PRESCALE_W_DEF = 16;
  localparam int unsigned FILT_CNT_W_DEF = 4;

endpackage

// File: rtl/gpio_controller_in_filter_bit.sv
// One GPIO pin: synchroniser chain, tick-qualified stability counter and the
// registered clean output bit.
module gpio_controller_in_filter_bit
  import gpio_controller_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CNT_W  = FILT_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  raw,
  input  logic                  enable,
  input  logic                  tick,
  input  logic [FILT_CNT_W-1:0] threshold,
  output logic                  data
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [FILT_CNT_W-1:0]  count;
  logic [FILT_CNT_W-1:0]  count_nxt;
  logic                   data_nxt;

  // Plain flop chain; no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // Same-level input clears first, so a glitch that returns on a tick cycle
  // restarts qualification instead of advancing it.
  always_comb begin
    data_nxt  = data;
    count_nxt = count;
    if (!enable) begin
      data_nxt  = s;
      count_nxt = '0;
    end else if (s == data) begin
      count_nxt = '0;
    end else if (tick) begin
      if (count >= threshold) begin
        data_nxt  = s;
        count_nxt = '0;
      end else begin
        count_nxt = count + FILT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= 1'b0;
      count <= '0;
    end else begin
      data  <= data_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/gpio_controller_in_filter.sv
// GPIO input conditioning: per-pin synchronise + glitch filter, sharing one
// free-running tick prescaler across all pins.
module gpio_controller_in_filter
  import gpio_controller_pkg::*;
#(
  parameter int unsigned NUM_GPIO    = GPIO_NUM,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRESCALE_W  = PRESCALE_W_DEF,
  parameter int unsigned FILT_CNT_W  = FILT_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_GPIO-1:0]   gpio_in_raw,
  input  logic [NUM_GPIO-1:0]   filter_enable,
  input  logic [PRESCALE_W-1:0] prescale_div,
  input  logic [FILT_CNT_W-1:0] filter_threshold,
  output logic [NUM_GPIO-1:0]   gpio_in_data,
  output logic                  filter_tick
);

  logic [PRESCALE_W-1:0] presc_count;

  // >= compare lets a lowered divider wrap immediately rather than stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_count <= '0;
      filter_tick <= 1'b0;
    end else if (presc_count >= prescale_div) begin
      presc_count <= '0;
      filter_tick <= 1'b1;
    end else begin
      presc_count <= presc_count + PRESCALE_W'(1);
      filter_tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < int'(NUM_GPIO); i++) begin : g_pin
    gpio_controller_in_filter_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CNT_W (FILT_CNT_W)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (gpio_in_raw[i]),
      .enable   (filter_enable[i]),
      .tick     (filter_tick),
      .threshold(filter_threshold),
      .data     (gpio_in_data[i])
    );
  end

endmodule
